// File: rtl/ram_pkg.sv
// Shared types, latency limits and the byte-lane merge helper used by the
// ram_sx_be_clr scratch RAM and its storage core.
package ram_pkg;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

    localparam int CLatMin   = 1;
    localparam int CLatMax   = 2;
    localparam int CMaxData  = 512;
    localparam int CMaxLanes = CMaxData / 8;

    // Operands are zero-extended to CMaxData so one function serves every data width.
    function automatic logic [CMaxData-1:0] lane_merge(
        input logic [CMaxData-1:0]  old_word,
        input logic [CMaxData-1:0]  new_word,
        input logic [CMaxLanes-1:0] mask
    );
        logic [CMaxData-1:0] res;
        res = old_word;
        for (int i = 0; i < CMaxLanes; i++) begin
            if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_sx_be_core.sv
// Storage array with per-lane writes and one registered read port that returns
// either the merged (write-through) or the pre-write word on a same-cycle write.
module ram_sx_be_core
    import ram_pkg::*;
#(
    parameter int CIdxLen    = 10,
    parameter int CDataLen   = 32,
    parameter int CMemSize   = 1024,
    parameter int CWrThrough = 1
) (
    input  logic                  AClkH,
    input  logic                  AClkHEn,
    input  logic                  AWe,
    input  logic                  ARe,
    input  logic [CIdxLen-1:0]    AIdx,
    input  logic [CDataLen-1:0]   AWrData,
    input  logic [CDataLen/8-1:0] AByteEn,
    output logic [CDataLen-1:0]   ARdData
);

    logic [CDataLen-1:0] mem_q [CMemSize];
    logic [CDataLen-1:0] old_word;
    logic [CDataLen-1:0] merged_word;
    logic [CDataLen-1:0] rd_d;
    logic [CDataLen-1:0] rd_q;

    assign old_word    = mem_q[AIdx];
    assign merged_word = CDataLen'(lane_merge(CMaxData'(old_word), CMaxData'(AWrData),
                                              CMaxLanes'(AByteEn)));

    always_comb begin
        rd_d = rd_q;
        if (ARe) rd_d = (CWrThrough != 0) ? merged_word : old_word;
    end

    // The top never asserts AWe for an index at or beyond CMemSize.
    always_ff @(posedge AClkH) begin
        if (AClkHEn) begin
            rd_q <= rd_d;
            if (AWe) mem_q[AIdx] <= merged_word;
        end
    end

    assign ARdData = rd_q;

endmodule

// File: rtl/ram_sx_be_clr.sv
// Single-port byte-enable RAM with a hardware clear engine, range check,
// selectable read latency (1 or 2) and a zero-gated valid-qualified read port.
module ram_sx_be_clr
    import ram_pkg::*;
#(
    parameter int CAddrLen    = 10,
    parameter int CDataLen    = 32,
    parameter int CMemSize    = 2**CAddrLen,
    parameter int CRdLat      = 1,
    parameter int CWrThrough  = 1,
    parameter int CClrOnReset = 1
) (
    input  logic                  AClkH,
    input  logic                  AResetH,
    input  logic                  AClkHEn,
    input  logic [CAddrLen-1:0]   AAddr,
    input  logic [CDataLen-1:0]   AMosi,
    input  logic [CDataLen/8-1:0] AByteEn,
    input  logic                  AWrEn,
    input  logic                  ARdEn,
    input  logic                  AClrReq,
    output logic [CDataLen-1:0]   AMiso,
    output logic                  AMisoVld,
    output logic                  ABusy,
    output state_e                ADbgState
);

    localparam int CLanes  = CDataLen / 8;
    localparam int CIdxLen = (CMemSize > 1) ? $clog2(CMemSize) : 1;
    // Latencies outside 1..2 fall back to the single-stage read path.
    localparam bit CTwoStage = (CRdLat > CLatMin) && (CRdLat <= CLatMax);
    localparam state_e CRstState = (CClrOnReset != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [CAddrLen-1:0] CLastAddr = CAddrLen'(CMemSize - 1);
    localparam logic [CAddrLen:0]   CSizeExt  = (CAddrLen+1)'(CMemSize);

    state_e                state_q, state_d;
    logic [CAddrLen-1:0]   cnt_q, cnt_d;
    logic                  s1_vld_q, s1_vld_d;
    logic                  s1_oob_q, s1_oob_d;
    logic                  in_range;
    logic                  core_we, core_re;
    logic [CIdxLen-1:0]    core_idx;
    logic [CDataLen-1:0]   core_wdata, core_rd, s1_data;
    logic [CLanes-1:0]     core_be;

    assign in_range = ({1'b0, AAddr} < CSizeExt);

    // While clearing, the engine owns the array port and user requests are dropped.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        core_we    = 1'b0;
        core_re    = 1'b0;
        core_idx   = AAddr[CIdxLen-1:0];
        core_wdata = AMosi;
        core_be    = AByteEn;
        s1_vld_d   = 1'b0;
        s1_oob_d   = 1'b0;
        if (state_q == ST_CLEAR) begin
            core_we    = 1'b1;
            core_idx   = cnt_q[CIdxLen-1:0];
            core_wdata = '0;
            core_be    = '1;
            if (cnt_q == CLastAddr) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CAddrLen'(1);
            end
        end else if (AClrReq) begin
            state_d = ST_CLEAR;
        end else begin
            core_we  = AWrEn && in_range;
            core_re  = ARdEn;
            s1_vld_d = ARdEn;
            s1_oob_d = !in_range;
        end
    end

    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            state_q  <= CRstState;
            cnt_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_oob_q <= 1'b0;
        end else if (AClkHEn) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s1_vld_q <= s1_vld_d;
            s1_oob_q <= s1_oob_d;
        end
    end

    ram_sx_be_core #(
        .CIdxLen    (CIdxLen),
        .CDataLen   (CDataLen),
        .CMemSize   (CMemSize),
        .CWrThrough (CWrThrough)
    ) u_core (
        .AClkH   (AClkH),
        .AClkHEn (AClkHEn),
        .AWe     (core_we),
        .ARe     (core_re),
        .AIdx    (core_idx),
        .AWrData (core_wdata),
        .AByteEn (core_be),
        .ARdData (core_rd)
    );

    // Read port has no back-pressure: AMisoVld marks a one-cycle valid beat and
    // AMiso is forced to zero whenever it is low or the address was out of range.
    assign s1_data = (s1_vld_q && !s1_oob_q) ? core_rd : '0;

    if (CTwoStage) begin : g_lat2
        logic                s2_vld_q, s2_vld_d;
        logic [CDataLen-1:0] s2_data_q, s2_data_d;

        assign s2_vld_d  = s1_vld_q;
        assign s2_data_d = s1_data;

        always_ff @(posedge AClkH or posedge AResetH) begin
            if (AResetH) begin
                s2_vld_q  <= 1'b0;
                s2_data_q <= '0;
            end else if (AClkHEn) begin
                s2_vld_q  <= s2_vld_d;
                s2_data_q <= s2_data_d;
            end
        end

        assign AMiso    = s2_data_q;
        assign AMisoVld = s2_vld_q;
    end else begin : g_lat1
        assign AMiso    = s1_data;
        assign AMisoVld = s1_vld_q;
    end

    assign ABusy     = (state_q == ST_CLEAR);
    assign ADbgState = state_q;

endmodule

// File: tb/tb_ram_sx_be_clr.sv
// Bench for ram_sx_be_clr: three differently configured instances share one
// stimulus stream and are checked every cycle against an array/queue model.
module tb_ram_sx_be_clr;
    import ram_pkg::*;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] mosi = '0;
    logic [3:0]  be   = '0;
    logic        wr = 1'b0, rd = 1'b0, clr = 1'b0;

    logic [31:0] miso [NI];
    logic        vld  [NI];
    logic        busy [NI];
    state_e      st   [NI];

    // Instance configuration: d0 full depth lat1 write-through, d1 partial depth
    // lat2 old-data, d2 partial depth (16 of 32) lat1 old-data without reset clear.
    int msize   [NI] = '{16, 12, 16};
    int lat     [NI] = '{1, 2, 1};
    int wt      [NI] = '{1, 0, 0};
    int clr_rst [NI] = '{1, 1, 0};
    int amask   [NI] = '{15, 15, 31};

    logic [31:0] mem [NI][32];
    int          clr_left [NI];
    int          clr_pos  [NI];
    logic        pv [NI][2];
    logic [31:0] pd [NI][2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_sx_be_clr #(.CAddrLen(4), .CDataLen(32), .CMemSize(16), .CRdLat(1),
                    .CWrThrough(1), .CClrOnReset(1)) d0 (
        .AClkH(clk), .AResetH(rst), .AClkHEn(en), .AAddr(addr[3:0]), .AMosi(mosi),
        .AByteEn(be), .AWrEn(wr), .ARdEn(rd), .AClrReq(clr), .AMiso(miso[0]),
        .AMisoVld(vld[0]), .ABusy(busy[0]), .ADbgState(st[0]));

    ram_sx_be_clr #(.CAddrLen(4), .CDataLen(32), .CMemSize(12), .CRdLat(2),
                    .CWrThrough(0), .CClrOnReset(1)) d1 (
        .AClkH(clk), .AResetH(rst), .AClkHEn(en), .AAddr(addr[3:0]), .AMosi(mosi),
        .AByteEn(be), .AWrEn(wr), .ARdEn(rd), .AClrReq(clr), .AMiso(miso[1]),
        .AMisoVld(vld[1]), .ABusy(busy[1]), .ADbgState(st[1]));

    ram_sx_be_clr #(.CAddrLen(5), .CDataLen(32), .CMemSize(16), .CRdLat(1),
                    .CWrThrough(0), .CClrOnReset(0)) d2 (
        .AClkH(clk), .AResetH(rst), .AClkHEn(en), .AAddr(addr), .AMosi(mosi),
        .AByteEn(be), .AWrEn(wr), .ARdEn(rd), .AClrReq(clr), .AMiso(miso[2]),
        .AMisoVld(vld[2]), .ABusy(busy[2]), .ADbgState(st[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            clr_left[i] = (clr_rst[i] != 0) ? msize[i] : 0;
            clr_pos[i]  = 0;
            pv[i][0] = 1'b0; pv[i][1] = 1'b0;
            pd[i][0] = '0;   pd[i][1] = '0;
        end
    endtask

    // One enabled clock edge of each configuration, from the behavioural rules.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            int          a;
            logic [31:0] old_w, mrg, nd;
            logic        nv;
            a  = int'(addr) & amask[i];
            nv = 1'b0;
            nd = '0;
            if (clr_left[i] > 0) begin
                mem[i][5'(clr_pos[i])] = '0;
                clr_pos[i]++;
                clr_left[i]--;
            end else if (clr) begin
                clr_left[i] = msize[i];
                clr_pos[i]  = 0;
            end else begin
                old_w = (a < msize[i]) ? mem[i][5'(a)] : 32'h0;
                mrg   = old_w;
                for (int k = 0; k < 4; k++) if (be[k]) mrg[8*k +: 8] = mosi[8*k +: 8];
                if (rd) begin
                    nv = 1'b1;
                    nd = (a >= msize[i]) ? 32'h0 : ((wt[i] != 0) ? mrg : old_w);
                end
                if (wr && a < msize[i]) mem[i][5'(a)] = mrg;
            end
            pv[i][1] = pv[i][0]; pd[i][1] = pd[i][0];
            pv[i][0] = nv;       pd[i][0] = nd;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NI; i++) begin
            logic        ev;
            logic [31:0] ed;
            ev = (lat[i] == 2) ? pv[i][1] : pv[i][0];
            ed = (lat[i] == 2) ? pd[i][1] : pd[i][0];
            if (!ev) ed = '0;
            chk($sformatf("vld_d%0d", i),   32'(vld[i]),  32'(ev));
            chk($sformatf("miso_d%0d", i),  miso[i],      ed);
            chk($sformatf("busy_d%0d", i),  32'(busy[i]), 32'(clr_left[i] > 0));
            chk($sformatf("state_d%0d", i), 32'(st[i]),
                32'((clr_left[i] > 0) ? ST_CLEAR : ST_IDLE));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (en && !rst) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        wr = 1'b0; rd = 1'b0; clr = 1'b0; be = '0; mosi = '0; en = 1'b1;
    endtask

    task automatic drive(input logic w, input logic r, input logic c, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        wr = w; rd = r; clr = c; addr = a; mosi = d; be = b; en = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
    endtask

    // Runs idle cycles until every model is out of CLEAR; counts DUT busy cycles.
    task automatic wait_clear(input int budget, output int c0, output int c1, output int c2);
        int n;
        n  = 0;
        idle();
        c0 = int'(busy[0]); c1 = int'(busy[1]); c2 = int'(busy[2]);
        while ((clr_left[0] > 0 || clr_left[1] > 0 || clr_left[2] > 0) && n < budget) begin
            step();
            n++;
            c0 += int'(busy[0]); c1 += int'(busy[1]); c2 += int'(busy[2]);
        end
        chk("clear_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, c1, c2;
        for (int i = 0; i < NI; i++) for (int j = 0; j < 32; j++) mem[i][j] = '0;
        idle();
        @(negedge clk);
        do_reset();
        wait_clear(64, c0, c1, c2);
        chk("rst_clear_len_d0", 32'(c0), 32'd16);
        chk("rst_clear_len_d1", 32'(c1), 32'd12);
        chk("rst_clear_len_d2", 32'(c2), 32'd0);

        // Clear request colliding with a write, then a write+read while busy.
        drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h55, 4'hF); step();
        idle(); step(); step(); step();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h77, 4'hF); step();
        chk("busy_drop_vld_d0", 32'(vld[0]), 32'd0);
        wait_clear(64, c0, c1, c2);

        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b1, 1'b0, 5'(a), 32'h0, 4'h0); step();
        end
        idle(); step(); step();
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0); step();
        chk("clr_drop_wr_data", miso[0], 32'h0);
        chk("clr_drop_wr_vld", 32'(vld[0]), 32'd1);

        // Byte-lane merge.
        drive(1'b1, 1'b0, 1'b0, 5'd3, 32'hAABBCCDD, 4'hF); step();
        drive(1'b1, 1'b0, 1'b0, 5'd3, 32'h11223344, 4'h5); step();
        drive(1'b0, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0); step();
        chk("lane_merge_d0", miso[0], 32'hAA22CC44);
        chk("lane_merge_d2", miso[2], 32'hAA22CC44);
        idle(); step();
        chk("lane_merge_d1", miso[1], 32'hAA22CC44);

        // Read during write.
        drive(1'b1, 1'b0, 1'b0, 5'd5, 32'hFFFFFFFF, 4'hF); step();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h12345678, 4'h3); step();
        chk("rdw_through_d0", miso[0], 32'hFFFF5678);
        chk("rdw_old_d2", miso[2], 32'hFFFFFFFF);
        idle(); step();
        chk("rdw_old_d1", miso[1], 32'hFFFFFFFF);
        drive(1'b0, 1'b1, 1'b0, 5'd5, 32'h0, 4'h0); step();
        chk("rdw_after_d2", miso[2], 32'hFFFF5678);

        // Back-to-back reads with a clock-enable gap on the lat-2 pipeline.
        drive(1'b1, 1'b0, 1'b0, 5'd1, 32'h01010101, 4'hF); step();
        drive(1'b1, 1'b0, 1'b0, 5'd2, 32'h02020202, 4'hF); step();
        drive(1'b0, 1'b1, 1'b0, 5'd1, 32'h0, 4'h0); step();
        drive(1'b0, 1'b1, 1'b0, 5'd2, 32'h0, 4'h0); step();
        chk("pipe_first_d1", miso[1], 32'h01010101);
        drive(1'b0, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0); en = 1'b0; step();
        chk("pipe_hold_d1", miso[1], 32'h01010101);
        chk("pipe_hold_vld_d1", 32'(vld[1]), 32'd1);
        en = 1'b1; step();
        chk("pipe_second_d1", miso[1], 32'h02020202);
        idle(); step();
        chk("pipe_third_d1", miso[1], 32'hAA22CC44);
        step();

        // Out-of-range accesses (13 for d1, 20 for d2).
        drive(1'b1, 1'b0, 1'b0, 5'd13, 32'h99, 4'hF); step();
        drive(1'b1, 1'b0, 1'b0, 5'd20, 32'h99, 4'hF); step();
        drive(1'b0, 1'b1, 1'b0, 5'd13, 32'h0, 4'h0); step();
        drive(1'b0, 1'b1, 1'b0, 5'd20, 32'h0, 4'h0); step();
        chk("oob_d2_data", miso[2], 32'h0);
        chk("oob_d1_data", miso[1], 32'h0);
        chk("oob_d1_vld", 32'(vld[1]), 32'd1);
        idle(); step(); step();

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 60) == 0), 5'($urandom_range(0, 31)),
                  $urandom, 4'($urandom_range(0, 15)));
            en = ($urandom_range(0, 9) != 0);
            step();
        end
        wait_clear(64, c0, c1, c2);

        // Reset in the middle of a clear.
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 4'h0); step();
        idle(); step(); step(); step(); step(); step();
        do_reset();
        wait_clear(64, c0, c1, c2);
        chk("midclr_rst_len_d0", 32'(c0), 32'd16);
        chk("midclr_rst_len_d1", 32'(c1), 32'd12);
        chk("midclr_rst_len_d2", 32'(c2), 32'd0);
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b1, 1'b0, 5'(a), 32'h0, 4'h0); step();
        end
        idle(); step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sx_be_clr.md
Name: ram_sx_be_clr

Overview:
- Single-port synchronous RAM, successor to the plain single-port write-through RAM.
- Adds per-byte write enables, a selectable read-during-write mode, selectable read latency (1 or 2), partial depth and an output valid flag.
- Includes a hardware clear engine that zeroes the array after reset or on request.
- Used as the local data/scratch store for processor cores and DMA buffers.

Parameters:
- CAddrLen, 10, address width in bits.
- CDataLen, 32, data width in bits; must be a multiple of 8.
- CMemSize, 2**CAddrLen, number of implemented words; must be ≤ 2**CAddrLen.
- CRdLat, 1, read latency in enabled cycles; legal values 1 or 2.
- CWrThrough, 1, read-during-write mode: 1 returns the merged new word, 0 returns the old word.
- CClrOnReset, 1, 1 runs an automatic clear after reset release.

Ports:
- AClkH  in  1  clock, rising edge.
- AResetH  in  1  asynchronous reset, active-high.
- AClkHEn  in  1  clock enable; all state, including the array, advances only when it is 1.
- AAddr  in  CAddrLen  word address.
- AMosi  in  CDataLen  write data.
- AByteEn  in  CDataLen/8  write lane mask; bit i covers bits [8i+7:8i].
- AWrEn  in  1  write request.
- ARdEn  in  1  read request; a write with ARdEn=1 also returns data.
- AClrReq  in  1  single-cycle pulse requesting a full clear.
- AMiso  out  CDataLen  read data; all-zero whenever AMisoVld=0.
- AMisoVld  out  1  AMiso is valid this cycle.
- ABusy  out  1  clear in progress; user accesses are dropped.

Behaviour:
- Reset values:
  - AMiso=0, AMisoVld=0, pipeline valid bits=0.
  - Clear counter=0.
  - State=CLEAR with ABusy=1 if CClrOnReset=1, else IDLE with ABusy=0.
  - Array contents are not reset.
- States:
  - IDLE: user accesses are served. AClrReq=1 drops that cycle's access and moves to CLEAR next enabled cycle.
  - CLEAR: writes zero (all lanes) to address cnt, then cnt++, once per enabled cycle. At cnt==CMemSize-1 the last write happens and the state returns to IDLE; ABusy falls on the following cycle. AClrReq is ignored in CLEAR.
  - Clear takes exactly CMemSize enabled cycles.
- Write:
  - In IDLE with AWrEn=1 and AAddr<CMemSize, lane i is updated iff AByteEn[i]=1.
  - AByteEn=0 is a legal no-op write.
- Read:
  - Requested by ARdEn=1 in IDLE.
  - CRdLat=1: data and AMisoVld appear one enabled cycle after the request.
  - CRdLat=2: two enabled cycles after; fully pipelined, one request per cycle.
- Read-during-write (AWrEn=1 and ARdEn=1, same cycle):
  - CWrThrough=1 returns the merged word: AMosi on enabled lanes, old data on the others.
  - CWrThrough=0 returns the pre-write word.
- Out-of-range address (AAddr ≥ CMemSize):
  - Writes are ignored.
  - Reads return 0 with AMisoVld=1.
- Requests made while ABusy=1 are dropped: no write, no valid.
- Reads issued before a clear request still complete through the pipeline with pre-clear data.
- AClkHEn=0 freezes everything: outputs hold, counter holds, no array write.
- Reset mid-clear restarts the clear from address 0 (CClrOnReset=1) or aborts to IDLE (CClrOnReset=0).
- Counter width is CAddrLen; no wrap occurs because termination is at CMemSize-1.

Decomposition:
- Shared package ram_pkg:
  - State enum {ST_IDLE, ST_CLEAR}.
  - Constants CLatMin=1, CLatMax=2.
  - Function for the byte-lane merge (old, new, mask).
- Sub-module ram_sx_be_core:
  - Storage array with per-lane write.
  - One registered read port implementing both read-during-write modes.
- The top level holds the clear FSM and counter, the access mux, the range check, the optional second pipeline stage and the valid/zero gating.

Test Plan:
- Reset release with CClrOnReset=1, CMemSize=16 -> ABusy=1 for exactly 16 enabled cycles; then reads of addr 0..15 return 0x00000000 with AMisoVld=1.
- Write 0xAABBCCDD to addr 3 with AByteEn=4'b1111, then write 0x11223344 with AByteEn=4'b0101, then read addr 3 -> AMiso=0xAA22CC44.
- Write 0x12345678 with ARdEn=1 to addr 5, which holds 0xFFFFFFFF, AByteEn=4'b0011 -> CWrThrough=1 returns 0xFFFF5678; CWrThrough=0 returns 0xFFFFFFFF.
- CRdLat=2: back-to-back reads of addr 1,2,3 on consecutive cycles -> AMisoVld high for three cycles starting 2 cycles later, data in order; AClkHEn=0 for one cycle mid-stream -> outputs hold, none lost.
- AClrReq pulse together with a write of 0x55 to addr 7 -> the write is dropped, ABusy=1 from the next cycle, a read after ABusy falls returns 0; assert AResetH mid-clear -> counter restarts at 0 and a full 16-cycle clear follows.
- CMemSize=12, CAddrLen=4: write 0x99 to addr 13, read addr 13 -> AMiso=0, AMisoVld=1; addr 0..11 unchanged.
